// File: rtl/iob_sipo_deser_pkg.sv
// rtl/iob_sipo_deser_pkg.sv - shared defaults and width helper for the SIPO deserializer
package iob_sipo_deser_pkg;

  localparam int unsigned SIPO_DATA_W_DEFAULT = 32;

  function automatic int unsigned cnt_width(input int unsigned data_w);
    return $clog2(data_w);
  endfunction

endpackage

// File: rtl/iob_sipo_reg_re.sv
// rtl/iob_sipo_reg_re.sv - shift register with sync reset and enable, serial in at the LSB
module iob_sipo_reg_re #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              s_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= {data_q[DATA_W-2:0], s_i};
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/iob_sipo_deser.sv
// rtl/iob_sipo_deser.sv - MSB-first serial-to-parallel deserializer with framing, handshake and overrun
module iob_sipo_deser
  import iob_sipo_deser_pkg::*;
#(
  parameter int DATA_W = SIPO_DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic              s_in,
  output logic [DATA_W-1:0] p_out,
  output logic              p_valid,
  input  logic              p_ready,
  output logic              busy,
  output logic              overrun,
  input  logic              overrun_clr
);

  localparam int CNT_W = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] sr;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_eff;
  logic [DATA_W-1:0] p_out_q, p_out_d;
  logic              p_valid_q, p_valid_d;
  logic              overrun_q, overrun_d;
  logic [DATA_W-1:0] word;
  logic              complete, slot_free, pop, drop;

  iob_sipo_reg_re #(.DATA_W(DATA_W)) u_sr (
    .clk_i  (clk),
    .rst_i  (rst),
    .en_i   (en),
    .s_i    (s_in),
    .data_o (sr)
  );

  // start realigns the current bit to position 0, even on what would be the final bit
  assign cnt_eff   = start ? '0 : cnt_q;
  assign word      = {sr[DATA_W-2:0], s_in};
  assign complete  = en && (cnt_eff == LAST_BIT);
  assign pop       = p_valid_q && p_ready;
  assign slot_free = !p_valid_q || p_ready;
  assign drop      = complete && !slot_free;

  always_comb begin
    cnt_d     = cnt_q;
    p_out_d   = p_out_q;
    p_valid_d = p_valid_q;
    if (en) begin
      cnt_d = complete ? '0 : cnt_eff + CNT_W'(1);
    end else if (start) begin
      cnt_d = '0;
    end
    if (complete && slot_free) begin
      p_out_d   = word;
      p_valid_d = 1'b1;
    end else if (pop) begin
      p_valid_d = 1'b0;
    end
    overrun_d = drop || (overrun_q && !overrun_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      p_out_q   <= '0;
      p_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      p_out_q   <= p_out_d;
      p_valid_q <= p_valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign p_out   = p_out_q;
  assign p_valid = p_valid_q;
  assign busy    = (cnt_q != '0);
  assign overrun = overrun_q;

endmodule

// File: tb/tb_iob_sipo_deser.sv
// tb/tb_iob_sipo_deser.sv - table-driven bench for iob_sipo_deser at DATA_W=8
module tb_iob_sipo_deser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       start = 1'b0;
  logic       s_in = 1'b0;
  logic       p_ready = 1'b0;
  logic       overrun_clr = 1'b0;
  logic [7:0] p_out;
  logic       p_valid;
  logic       busy;
  logic       overrun;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  iob_sipo_deser #(.DATA_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .start       (start),
    .s_in        (s_in),
    .p_out       (p_out),
    .p_valid     (p_valid),
    .p_ready     (p_ready),
    .busy        (busy),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  typedef struct packed {
    logic       rst;
    logic       en;
    logic       start;
    logic       s;
    logic       rdy;
    logic       clr;
    logic [7:0] eo;
    logic       ev;
    logic       eb;
    logic       eovr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input bit r, input bit e, input bit st, input bit s, input bit rdy,
                     input bit clr, input logic [7:0] eo, input bit ev, input bit eb,
                     input bit eovr);
    vec_t v;
    v.rst = r; v.en = e; v.start = st; v.s = s; v.rdy = rdy; v.clr = clr;
    v.eo = eo; v.ev = ev; v.eb = eb; v.eovr = eovr;
    vq.push_back(v);
  endtask

  // first seven bits (b[7]..b[1]) of a byte; the caller adds the final bit explicitly
  task automatic bits7(input logic [7:0] b, input bit st0, input bit rdy,
                       input logic [7:0] eo, input bit ev, input bit eovr);
    for (int i = 7; i >= 1; i--) begin
      add(0, 1, (i == 7) ? st0 : 1'b0, b[i], rdy, 0, eo, ev, 1, eovr);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  int valid_seen;
  int first_at;
  int second_at;
  logic [7:0] w0, w1;
  logic [7:0] piso;

  initial begin
    // reset
    add(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
    // basic word 0xA5, valid for exactly one cycle
    bits7(8'hA5, 0, 1, 8'h00, 0, 0);
    add(0, 1, 0, 1, 1, 0, 8'hA5, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 8'hA5, 0, 0, 0);
    // overrun: hold 0x11, drop 0x22; clear on the dropping cycle loses to the set
    bits7(8'h11, 0, 0, 8'hA5, 0, 0);
    add(0, 1, 0, 1, 0, 0, 8'h11, 1, 0, 0);
    bits7(8'h22, 0, 0, 8'h11, 1, 0);
    add(0, 1, 0, 0, 0, 1, 8'h11, 1, 0, 1);
    add(0, 0, 0, 0, 1, 0, 8'h11, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 8'h11, 0, 0, 0);
    // simultaneous pop and completion
    bits7(8'h11, 0, 0, 8'h11, 0, 0);
    add(0, 1, 0, 1, 0, 0, 8'h11, 1, 0, 0);
    bits7(8'h22, 0, 0, 8'h11, 1, 0);
    add(0, 1, 0, 0, 1, 0, 8'h22, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 8'h22, 0, 0, 0);
    // resync: 3 stray bits then start-aligned 0x5A
    for (int i = 0; i < 3; i++) add(0, 1, 0, 1, 1, 0, 8'h22, 0, 1, 0);
    bits7(8'h5A, 1, 1, 8'h22, 0, 0);
    add(0, 1, 0, 0, 1, 0, 8'h5A, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 8'h5A, 0, 0, 0);
    // start on the final bit abandons the word; start alone clears the count
    bits7(8'h00, 0, 1, 8'h5A, 0, 0);
    add(0, 1, 1, 0, 1, 0, 8'h5A, 0, 1, 0);
    add(0, 0, 1, 0, 1, 0, 8'h5A, 0, 0, 0);
    // reset mid-frame, then a clean 0xFF frame
    for (int i = 0; i < 5; i++) add(0, 1, 0, 1, 1, 0, 8'h5A, 0, 1, 0);
    add(1, 1, 0, 1, 1, 0, 8'h00, 0, 0, 0);
    bits7(8'hFF, 0, 1, 8'h00, 0, 0);
    add(0, 1, 0, 1, 1, 0, 8'hFF, 1, 0, 0);

    for (int k = 0; k < vq.size(); k++) begin
      @(negedge clk);
      rst = vq[k].rst; en = vq[k].en; start = vq[k].start; s_in = vq[k].s;
      p_ready = vq[k].rdy; overrun_clr = vq[k].clr;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d p_out", k), 32'(p_out), 32'(vq[k].eo));
      chk($sformatf("vec%0d p_valid", k), 32'(p_valid), 32'(vq[k].ev));
      chk($sformatf("vec%0d busy", k), 32'(busy), 32'(vq[k].eb));
      chk($sformatf("vec%0d overrun", k), 32'(overrun), 32'(vq[k].eovr));
    end

    // loopback from a PISO-style source: 0x3C then 0xC3 back to back
    @(negedge clk);
    rst = 1; en = 0; start = 0; p_ready = 1; overrun_clr = 0;
    @(negedge clk);
    rst = 0;
    valid_seen = 0; first_at = -1; second_at = -1; w0 = '0; w1 = '0;
    piso = 8'h3C;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 8) piso = 8'hC3;
      en = (c < 16);
      s_in = piso[7];
      piso = {piso[6:0], 1'b0};
      @(posedge clk);
      #1;
      if (p_valid) begin
        if (valid_seen == 0) begin w0 = p_out; first_at = c; end
        if (valid_seen == 1) begin w1 = p_out; second_at = c; end
        valid_seen++;
      end
    end
    en = 0;
    chk("loop words", 32'(valid_seen), 32'd2);
    chk("loop word0", 32'(w0), 32'h3C);
    chk("loop word1", 32'(w1), 32'hC3);
    chk("loop first_at", 32'(first_at), 32'd7);
    chk("loop spacing", 32'(second_at - first_at), 32'd8);
    chk("loop overrun", 32'(overrun), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
